// File: rtl/demux8x3_bank_pkg.sv
// rtl/demux8x3_bank_pkg.sv - shared sizes and helpers for the 1-to-8 slot demux
// Optional broadcast write is enabled by defining DEMUX8X3_BCAST_EN (undefined by default).
package demux8x3_bank_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SEL_W     = 3;
  localparam int CNT_W     = 4;

  typedef logic [NUM_SLOTS-1:0] slot_mask_t;

  function automatic logic [CNT_W-1:0] popcount(input slot_mask_t m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = n + CNT_W'(m[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/demux8x3_slot.sv
// rtl/demux8x3_slot.sv - one-entry slot buffer with valid flag and consumer ack
// A write in the same cycle as an ack wins: the slot stays valid with the new word.
module demux8x3_slot #(
  parameter int N = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  input  logic         ack,
  output logic [N-1:0] q,
  output logic         v
);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q <= '0;
      v <= 1'b0;
    end else if (wr_en) begin
      q <= wr_data;
      v <= 1'b1;
    end else if (ack) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/demux8x3_bank.sv
// rtl/demux8x3_bank.sv - registered 1-to-8 write demux feeding the 8:1 read mux
// Define DEMUX8X3_BCAST_EN to add the bcast input (write all eight slots at once).
module demux8x3_bank
  import demux8x3_bank_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [SEL_W-1:0] s,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       ack,
  output logic [N-1:0]     o0,
  output logic [N-1:0]     o1,
  output logic [N-1:0]     o2,
  output logic [N-1:0]     o3,
  output logic [N-1:0]     o4,
  output logic [N-1:0]     o5,
  output logic [N-1:0]     o6,
  output logic [N-1:0]     o7,
  output logic [7:0]       vld,
  output logic [CNT_W-1:0] count
`ifdef DEMUX8X3_BCAST_EN
  ,
  input  logic             bcast
`endif
);

  slot_mask_t       sel;
  slot_mask_t       open_slot;
  slot_mask_t       wr_en;
  logic             bc;
  logic             accept;
  logic [CNT_W-1:0] count_next;
  logic [N-1:0]     q [NUM_SLOTS];

`ifdef DEMUX8X3_BCAST_EN
  assign bc = bcast;
`else
  assign bc = 1'b0;
`endif

  // An unknown select matches no slot, so it can never write.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (s == SEL_W'(k)) sel[k] = 1'b1;
    end
  end

  assign open_slot = ~vld | ack;
  assign in_ready  = bc ? (&open_slot) : (|(sel & open_slot));
  assign accept    = in_valid & in_ready;
  assign wr_en     = accept ? (bc ? '1 : sel) : '0;

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      demux8x3_slot #(.N(N)) u_slot (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en   (wr_en[g]),
        .wr_data (in_data),
        .ack     (ack[g]),
        .q       (q[g]),
        .v       (vld[g])
      );
    end
  endgenerate

  assign o0 = q[0];
  assign o1 = q[1];
  assign o2 = q[2];
  assign o3 = q[3];
  assign o4 = q[4];
  assign o5 = q[5];
  assign o6 = q[6];
  assign o7 = q[7];

  // Rewritten slots neither fill nor drain; a broadcast fills every empty slot, landing on 8.
  assign count_next = count + popcount(wr_en & ~vld) - popcount(ack & vld & ~wr_en);

  always_ff @(posedge Clk) begin
    if (Rst) count <= '0;
    else     count <= count_next;
  end

  a_count_matches_vld: assert property (@(posedge Clk) count == popcount(vld));

endmodule

// File: tb/tb_demux8x3_bank.sv
// tb/tb_demux8x3_bank.sv - directed-vector bench for demux8x3_bank
// Broadcast vectors run only when DEMUX8X3_BCAST_EN is defined.
module tb_demux8x3_bank;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [2:0]  s;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ack;
  logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  vld;
  logic [3:0]  count;
`ifdef DEMUX8X3_BCAST_EN
  logic        bcast;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  demux8x3_bank #(.N(32)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .s        (s),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ack      (ack),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o4       (o4),
    .o5       (o5),
    .o6       (o6),
    .o7       (o7),
    .vld      (vld),
    .count    (count)
`ifdef DEMUX8X3_BCAST_EN
    ,
    .bcast    (bcast)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slot_out(input int k);
    case (k)
      0: return o0;
      1: return o1;
      2: return o2;
      3: return o3;
      4: return o4;
      5: return o5;
      6: return o6;
      default: return o7;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_slot(input logic [2:0] sel, input logic [31:0] d);
    s = sel; in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; s = '0; in_data = '0; in_valid = 1'b0; ack = '0;
`ifdef DEMUX8X3_BCAST_EN
    bcast = 1'b0;
`endif
    tick();
    tick();
    Rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) chk($sformatf("rst_o%0d", k), slot_out(k), 32'h0);
    chk("rst_vld", 32'(vld), 32'h00);
    chk("rst_count", 32'(count), 32'd0);
    for (int k = 0; k < 8; k++) begin
      s = 3'(k); #1;
      chk($sformatf("rst_ready_s%0d", k), 32'(in_ready), 32'd1);
    end

    write_slot(3'd3, 32'hDEADBEEF);
    chk("wr3_o3", o3, 32'hDEADBEEF);
    chk("wr3_vld", 32'(vld), 32'h08);
    chk("wr3_count", 32'(count), 32'd1);

    s = 3'd3; in_data = 32'h1234_5678; in_valid = 1'b1; #1;
    chk("full3_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("full3_o3", o3, 32'hDEADBEEF);
    chk("full3_vld", 32'(vld), 32'h08);
    chk("full3_count", 32'(count), 32'd1);

    // Drain slot 3 so the fill starts from empty; data must stay put.
    ack = 8'h08; tick(); ack = 8'h00;
    chk("ack3_vld", 32'(vld), 32'h00);
    chk("ack3_count", 32'(count), 32'd0);
    chk("ack3_o3_hold", o3, 32'hDEADBEEF);

    ack = 8'h20; #1;
    chk("ack_empty_ready", 32'(in_ready), 32'd1);
    tick(); ack = 8'h00;
    chk("ack_empty_vld", 32'(vld), 32'h00);
    chk("ack_empty_count", 32'(count), 32'd0);

    for (int k = 0; k < 8; k++) write_slot(3'(k), 32'(k + 1));
    for (int k = 0; k < 8; k++) chk($sformatf("fill_o%0d", k), slot_out(k), 32'(k + 1));
    chk("fill_vld", 32'(vld), 32'hFF);
    chk("fill_count", 32'(count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      s = 3'(k); #1;
      chk($sformatf("fill_ready_s%0d", k), 32'(in_ready), 32'd0);
    end

    ack = 8'h81; s = 3'd0; #1;
    chk("drain0_ready", 32'(in_ready), 32'd1);
    s = 3'd1; #1;
    chk("drain1_ready", 32'(in_ready), 32'd0);
    tick(); ack = 8'h00;
    chk("ack81_vld", 32'(vld), 32'h7E);
    chk("ack81_count", 32'(count), 32'd6);
    chk("ack81_o0", o0, 32'd1);
    chk("ack81_o7", o7, 32'd8);

    ack = 8'h20; write_slot(3'd5, 32'h55); ack = 8'h00;
    chk("wwin_o5", o5, 32'h55);
    chk("wwin_vld", 32'(vld), 32'h7E);
    chk("wwin_count", 32'(count), 32'd6);

    // Write to empty slot 0 while draining full slots 1 and 2: 6 + 1 - 2.
    ack = 8'h06; write_slot(3'd0, 32'h77); ack = 8'h00;
    chk("mix_o0", o0, 32'h77);
    chk("mix_vld", 32'(vld), 32'h79);
    chk("mix_count", 32'(count), 32'd5);

    s = 3'bx; in_data = 32'hBAD0_BAD0; in_valid = 1'b1; ack = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("xsel_vld", 32'(vld), 32'h79);
    chk("xsel_count", 32'(count), 32'd5);
    for (int k = 0; k < 8; k++)
      chk($sformatf("xsel_o%0d", k), slot_out(k), (k == 0) ? 32'h77 : (k == 5) ? 32'h55 : 32'(k + 1));

    Rst = 1'b1; s = 3'd4; in_data = 32'h99; in_valid = 1'b1;
    tick();
    Rst = 1'b0; in_valid = 1'b0;
    chk("rstwr_vld", 32'(vld), 32'h00);
    chk("rstwr_count", 32'(count), 32'd0);
    chk("rstwr_o4", o4, 32'h0);

`ifdef DEMUX8X3_BCAST_EN
    bcast = 1'b1; s = 3'd6; in_data = 32'hA5A5A5A5; in_valid = 1'b1; #1;
    chk("bc_ready_empty", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) chk($sformatf("bc_o%0d", k), slot_out(k), 32'hA5A5A5A5);
    chk("bc_vld", 32'(vld), 32'hFF);
    chk("bc_count", 32'(count), 32'd8);
    ack = 8'hFB; #1;
    chk("bc_ready_slot2_full", 32'(in_ready), 32'd0);
    ack = 8'hFF; #1;
    chk("bc_ready_all_ack", 32'(in_ready), 32'd1);
    ack = 8'h00; bcast = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1);
  end

endmodule
